// File: rtl/tdes_key_sched.sv
// tdes_key_sched: DES/TDES key schedule producing one 48-bit PC2 subkey per clock.
// Up to three keys are scheduled back-to-back in TDES order, each with its own E/D direction.
module tdes_key_sched #(
    parameter int KEY_NUM = 3,
    parameter int EDE     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  dec,
    input  logic [64*KEY_NUM-1:0] key_in,
    output logic [47:0]           sk,
    output logic                  sk_vld,
    output logic [3:0]            sk_rnd,
    output logic [1:0]            sk_kidx,
    output logic                  busy,
    output logic                  done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // DES bit n (1 = MSB) of a W-bit vector lives at index W-n.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int unsigned i = 0; i < 56; i++)
            r[6'(55 - i)] = k[6'(64 - PC1_T[6'(i)])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int unsigned j = 0; j < 48; j++)
            r[6'(47 - j)] = cd[6'(56 - PC2_T[6'(j)])];
        return r;
    endfunction

    // Key n (1-based) occupies the n-th 64-bit slice counted from the MSB end.
    function automatic logic [63:0] key_of(input logic [64*KEY_NUM-1:0] ks, input int unsigned n);
        logic [64*KEY_NUM-1:0] t;
        t = ks << (64 * (n - 1));
        return t[64*KEY_NUM-1 -: 64];
    endfunction

    function automatic int unsigned knum(input int unsigned pos, input logic d);
        return d ? (unsigned'(KEY_NUM) - pos) : (pos + 1);
    endfunction

    logic [0:0]             state;
    logic [64*KEY_NUM-1:0]  keys_q;
    logic                   dec_q;
    logic [27:0]            c_q, d_q;
    logic [3:0]             rnd_q;
    logic [1:0]             kidx_q;

    logic                   kdir;
    logic                   one;
    logic [27:0]            c_rot, d_rot;
    logic [55:0]            nxt_cd;
    logic                   last_rnd, last_key;

    assign busy     = (state == RUN) | done;
    assign last_rnd = (rnd_q == 4'd15);
    assign last_key = (kidx_q == 2'(KEY_NUM - 1));
    assign nxt_cd   = pc1(key_of(keys_q, knum(32'(kidx_q) + 1, dec_q)));

    // Decrypt round 1 reuses PC1 unrotated; later rounds undo the encrypt shifts in reverse.
    always_comb begin
        kdir = dec_q;
        if (EDE != 0 && KEY_NUM == 3 && kidx_q == 2'd1)
            kdir = ~dec_q;
        if (kdir)
            one = (rnd_q == 4'd1) || (rnd_q == 4'd8) || (rnd_q == 4'd15);
        else
            one = (rnd_q == 4'd0) || (rnd_q == 4'd1) || (rnd_q == 4'd8) || (rnd_q == 4'd15);
        c_rot = c_q;
        d_rot = d_q;
        if (!kdir) begin
            if (one) begin
                c_rot = {c_q[26:0], c_q[27]};
                d_rot = {d_q[26:0], d_q[27]};
            end else begin
                c_rot = {c_q[25:0], c_q[27:26]};
                d_rot = {d_q[25:0], d_q[27:26]};
            end
        end else if (rnd_q != 4'd0) begin
            if (one) begin
                c_rot = {c_q[0], c_q[27:1]};
                d_rot = {d_q[0], d_q[27:1]};
            end else begin
                c_rot = {c_q[1:0], c_q[27:2]};
                d_rot = {d_q[1:0], d_q[27:2]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            keys_q  <= '0;
            dec_q   <= 1'b0;
            c_q     <= '0;
            d_q     <= '0;
            rnd_q   <= '0;
            kidx_q  <= '0;
            sk      <= '0;
            sk_vld  <= 1'b0;
            sk_rnd  <= '0;
            sk_kidx <= '0;
            done    <= 1'b0;
        end else if (state == IDLE) begin
            sk_vld <= 1'b0;
            done   <= 1'b0;
            if (start && !busy) begin
                keys_q     <= key_in;
                dec_q      <= dec;
                {c_q, d_q} <= pc1(key_of(key_in, knum(0, dec)));
                rnd_q      <= '0;
                kidx_q     <= '0;
                state      <= RUN;
            end
        end else begin
            sk      <= pc2({c_rot, d_rot});
            sk_vld  <= 1'b1;
            sk_rnd  <= rnd_q;
            sk_kidx <= kidx_q;
            rnd_q   <= rnd_q + 4'd1;
            // Round 16 of a non-final key loads the next key so its round 1 follows directly.
            if (last_rnd && !last_key) begin
                {c_q, d_q} <= nxt_cd;
                kidx_q     <= kidx_q + 2'd1;
            end else begin
                {c_q, d_q} <= {c_rot, d_rot};
            end
            if (last_rnd && last_key) begin
                state <= IDLE;
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tdes_key_sched.sv
// Self-checking bench for tdes_key_sched: single-key and 3-key EDE instances against
// a textbook DES key-schedule model (cumulative rotations, reversed order for decrypt).
module tb_tdes_key_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start1, dec1, start3, dec3;
    logic [63:0]  key1_in;
    logic [191:0] key3_in;
    logic [47:0]  sk1, sk3;
    logic         sk_vld1, sk_vld3, busy1, busy3, done1, done3;
    logic [3:0]   sk_rnd1, sk_rnd3;
    logic [1:0]   sk_kidx1, sk_kidx3;

    tdes_key_sched #(.KEY_NUM(1), .EDE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dec(dec1), .key_in(key1_in),
        .sk(sk1), .sk_vld(sk_vld1), .sk_rnd(sk_rnd1), .sk_kidx(sk_kidx1),
        .busy(busy1), .done(done1)
    );

    tdes_key_sched #(.KEY_NUM(3), .EDE(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .dec(dec3), .key_in(key3_in),
        .sk(sk3), .sk_vld(sk_vld3), .sk_rnd(sk_rnd3), .sk_kidx(sk_kidx3),
        .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KF = 64'h133457799BBCDFF1;
    localparam logic [63:0] KA = 64'h0123456789ABCDEF;
    localparam logic [63:0] KB = 64'hFEDCBA9876543210;
    localparam logic [63:0] KD = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KE = 64'h3B3898371520F75E;
    localparam logic [63:0] KG = 64'h5B5A57676A56676E;

    typedef logic [15:0][47:0] ks_t;
    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  rnd;
        logic [1:0]  kidx;
        logic        last;
    } exp_t;

    exp_t        q1[$], q3[$];
    exp_t        e1, e3;
    logic        p1, p3;
    logic        armed1 = 1'b0, armed3 = 1'b0;
    logic [47:0] first1, last1;
    int          n_checks = 0, n_err = 0;
    ks_t         ks;
    logic        seen;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm, input logic [47:0] s, input logic v,
                            input logic [3:0] r, input logic [1:0] k, input logic b, input logic d);
        chk(nm, 64'({s, v, r, k, b, d}), 64'd0);
    endtask

    function automatic logic [27:0] rotl(input logic [27:0] x, input int s);
        logic [55:0] t;
        t = {x, x} << s;
        return t[55:28];
    endfunction

    // Standard DES: K_i = PC2(C0 <<< s_i, D0 <<< s_i), s_i the cumulative shift count.
    function automatic ks_t des_ks(input logic [63:0] key);
        logic [27:0] c0, d0;
        logic [55:0] cd;
        ks_t         r;
        int          s;
        c0 = '0; d0 = '0; r = '0; s = 0;
        for (int j = 0; j < 28; j++) begin
            c0[5'(27 - j)] = key[6'(64 - PC1[6'(j)])];
            d0[5'(27 - j)] = key[6'(64 - PC1[6'(28 + j)])];
        end
        for (int i = 0; i < 16; i++) begin
            s += SH[4'(i)];
            cd = {rotl(c0, s), rotl(d0, s)};
            for (int j = 0; j < 48; j++)
                r[4'(i)][6'(47 - j)] = cd[6'(56 - PC2[6'(j)])];
        end
        return r;
    endfunction

    task automatic push_run(input int dut, input logic d, input logic [63:0] ka, kb, kc);
        int          nk;
        logic [63:0] kk;
        logic        kd;
        ks_t         k;
        exp_t        e;
        nk = (dut == 1) ? 1 : 3;
        for (int p = 0; p < nk; p++) begin
            if (nk == 1)     kk = ka;
            else if (p == 1) kk = kb;
            else             kk = d ? ((p == 0) ? kc : ka) : ((p == 0) ? ka : kc);
            kd = (nk == 3 && p == 1) ? ~d : d;
            k  = des_ks(kk);
            for (int i = 0; i < 16; i++) begin
                e.sk   = kd ? k[4'(15 - i)] : k[4'(i)];
                e.rnd  = 4'(i);
                e.kidx = 2'(p);
                e.last = (p == nk - 1) && (i == 15);
                if (dut == 1) q1.push_back(e);
                else          q3.push_back(e);
            end
        end
    endtask

    task automatic cmp(input string nm, input logic vld, input logic [47:0] s, input logic [3:0] r,
                       input logic [1:0] k, input logic dn, input int qn, input exp_t e,
                       input logic armed, output logic pop);
        pop = 1'b0;
        if (vld) begin
            n_checks++;
            if (qn == 0) begin
                n_err++;
                $display("FAIL %s_vld: got sk_vld=1 expected 0 (no subkey pending)", nm);
            end else begin
                pop = 1'b1;
                chk({nm, "_sk"},   64'(s),  64'(e.sk));
                chk({nm, "_rnd"},  64'(r),  64'(e.rnd));
                chk({nm, "_kidx"}, 64'(k),  64'(e.kidx));
                chk({nm, "_done"}, 64'(dn), 64'(e.last));
            end
        end else begin
            chk({nm, "_done_idle"}, 64'(dn), 64'd0);
            if (armed && qn != 0) begin
                n_checks++;
                n_err++;
                $display("FAIL %s_gap: got sk_vld=0 expected 1 (%0d subkeys pending)", nm, qn);
            end
        end
    endtask

    always @(negedge clk) begin
        e1 = (q1.size() != 0) ? q1[0] : '0;
        cmp("u1", sk_vld1, sk1, sk_rnd1, sk_kidx1, done1, q1.size(), e1, armed1, p1);
        if (p1) begin
            if (e1.rnd == 4'd0)  first1 = sk1;
            if (e1.rnd == 4'd15) last1  = sk1;
            void'(q1.pop_front());
        end
        armed1 = (q1.size() != 0) && (p1 || armed1);
        e3 = (q3.size() != 0) ? q3[0] : '0;
        cmp("u3", sk_vld3, sk3, sk_rnd3, sk_kidx3, done3, q3.size(), e3, armed3, p3);
        if (p3) void'(q3.pop_front());
        armed3 = (q3.size() != 0) && (p3 || armed3);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_run(input int dut, input logic d, input logic [63:0] ka, kb, kc);
        if (dut == 1) begin dec1 = d; key1_in = ka;           start1 = 1'b1; end
        else          begin dec3 = d; key3_in = {ka, kb, kc}; start3 = 1'b1; end
        push_run(dut, d, ka, kb, kc);
        tick();
        if (dut == 1) begin
            start1 = 1'b0; dec1 = ~d; key1_in = ~ka;
            chk("u1_busy_lat", 64'({busy1, sk_vld1}), 64'b10);
        end else begin
            start3 = 1'b0; dec3 = ~d; key3_in = ~{ka, kb, kc};
            chk("u3_busy_lat", 64'({busy3, sk_vld3}), 64'b10);
        end
        tick();
        chk("first_vld_lat", 64'((dut == 1) ? sk_vld1 : sk_vld3), 64'd1);
    endtask

    task automatic wait_done(input int dut);
        for (int c = 0; c < 80; c++) begin
            if (((dut == 1) ? q1.size() : q3.size()) == 0) break;
            tick();
        end
        chk("run_complete", 64'((dut == 1) ? q1.size() : q3.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; dec1 = 1'b0; dec3 = 1'b0;
        key1_in = '0; key3_in = '0;

        ks = des_ks(KF);
        chk("model_k1",  64'(ks[0]),  64'h1B02EFFC7072);
        chk("model_k2",  64'(ks[1]),  64'h79AED9DBC9E5);
        chk("model_k16", 64'(ks[15]), 64'hCB3D8B0E17F5);
        ks = des_ks('1);
        chk("model_ones", 64'(ks[5]), 64'hFFFFFFFFFFFF);

        tick(); tick();
        chk_zero("u1_reset", sk1, sk_vld1, sk_rnd1, sk_kidx1, busy1, done1);
        chk_zero("u3_reset", sk3, sk_vld3, sk_rnd3, sk_kidx3, busy3, done3);
        rst_n = 1'b1;
        tick();

        start_run(1, 1'b0, KF, '0, '0);
        wait_done(1);
        chk("u1_enc_first", 64'(first1), 64'h1B02EFFC7072);
        chk("u1_enc_last",  64'(last1),  64'hCB3D8B0E17F5);
        tick();
        chk("u1_busy_after_done", 64'(busy1), 64'd0);

        start_run(1, 1'b1, KF, '0, '0);
        wait_done(1);
        chk("u1_dec_first", 64'(first1), 64'hCB3D8B0E17F5);
        chk("u1_dec_last",  64'(last1),  64'h1B02EFFC7072);
        tick();

        // 3-key encrypt with start pulses while busy, then a back-to-back decrypt run
        dec3 = 1'b0; key3_in = {KF, KA, KB}; start3 = 1'b1;
        push_run(3, 1'b0, KF, KA, KB);
        tick();
        chk("u3_busy_lat", 64'({busy3, sk_vld3}), 64'b10);
        dec3 = 1'b1; key3_in = ~key3_in;
        tick();
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (done3) begin
                seen = 1'b1;
                start3 = 1'b1;
                break;
            end
            start3 = sk_vld3 && (({sk_kidx3, sk_rnd3} == 6'd5) || ({sk_kidx3, sk_rnd3} == 6'd46));
            tick();
        end
        chk("u3_done_seen", 64'(seen), 64'd1);
        tick();
        chk("u3_busy_after_done", 64'(busy3), 64'd0);
        start_run(3, 1'b1, KD, KE, KG);
        wait_done(3);
        tick();
        chk("u3_busy_end", 64'(busy3), 64'd0);

        // asynchronous reset in round 7 of key position 1
        start_run(3, 1'b0, KA, KB, KF);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (sk_vld3 && sk_kidx3 == 2'd1 && sk_rnd3 == 4'd7) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("u3_reached_k1r7", 64'(seen), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_zero("u3_async_reset", sk3, sk_vld3, sk_rnd3, sk_kidx3, busy3, done3);
        q3.delete();
        armed3 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("u3_idle_after_reset", 64'({sk_vld3, busy3}), 64'd0);
        end

        start_run(3, 1'b0, '1, '1, '1);
        wait_done(3);
        tick();
        start_run(1, 1'b1, '0, '0, '0);
        wait_done(1);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
